// File: rtl/pulse_event_spacer.sv
// pulse_event_spacer: queues bursty source-domain events and re-issues them as spaced single-cycle pulses.
// Define PULSE_SPACER_DROP_CNT_EN to add the saturating drop_cnt output.
module pulse_event_spacer #(
  parameter int CTR_WIDTH  = 10,
  parameter int PEND_WIDTH = 4
) (
  input  logic                  clk_src,
  input  logic                  rst_n_src,
  input  logic [CTR_WIDTH-1:0]  cfg_stretch_val,
  input  logic [CTR_WIDTH-1:0]  cfg_gap_val,
  input  logic                  ev_in,
  input  logic                  clr_ovf,
  output logic                  sig_out,
  output logic [PEND_WIDTH-1:0] pend_cnt,
  output logic                  busy,
  output logic                  overflow
`ifdef PULSE_SPACER_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_e;
  state_e                state_q;
  logic [CTR_WIDTH:0]    wait_q, sum;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  sig_q, busy_q, ovf_q, ovf_d, issue, drop;
  // One bit wider so stretch+gap never wraps.
  assign sum = {1'b0, cfg_stretch_val} + {1'b0, cfg_gap_val};
  assign issue = (state_q == IDLE) && (pend_q != '0);
  assign drop = ev_in && !issue && (&pend_q);
  assign pend_d = drop ? pend_q : pend_q + PEND_WIDTH'(ev_in) - PEND_WIDTH'(issue);
  assign ovf_d = drop | (ovf_q & ~clr_ovf);
  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      state_q <= IDLE;
      wait_q  <= '0;
      pend_q  <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      case (state_q)
        IDLE: if (issue) begin
          state_q <= EMIT;
          sig_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
        EMIT: begin
          sig_q  <= 1'b0;
          wait_q <= sum;
          if (sum == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else state_q <= WAIT;
        end
        WAIT: begin
          wait_q <= wait_q - (CTR_WIDTH+1)'(1);
          if (wait_q == (CTR_WIDTH+1)'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sig_out  = sig_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;
`ifdef PULSE_SPACER_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  // A clear coinciding with a drop leaves exactly that one drop counted.
  assign drop_d = clr_ovf ? {7'b0, drop} : (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  always_ff @(posedge clk_src or negedge rst_n_src)
    if (!rst_n_src) drop_q <= '0;
    else drop_q <= drop_d;
  assign drop_cnt = drop_q;
`endif
endmodule
